// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: turnaround-safe single-word exchanger between two pulled-up bidirectional buses.
// Releases both buses for TA cycles, captures from the source, then drives the destination for HOLD cycles.
module bus_xfer_ctrl #(
    parameter int WIDTH = 16,
    parameter int TA    = 1,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] busa,
    inout  wire  [WIDTH-1:0] busb,
    input  logic             req_a2b,
    input  logic             req_b2a,
    output logic             oe0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_q
);
    localparam int CW = $clog2((TA > HOLD ? TA : HOLD) + 1);
    localparam logic [CW-1:0] TA_M1   = CW'(TA - 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, TURN, CAP, DRV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             oe0_q, oe0_d;
    logic             last_q, last_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] data_d;
    logic             grant_dir;

    // Conflicts go to the direction not served last; last_q resets to B->A.
    assign grant_dir = (req_a2b && req_b2a) ? !last_q : req_b2a;

    assign busa = (state_q == DRV && oe0_q)  ? data_q : 'z;
    assign busb = (state_q == DRV && !oe0_q) ? data_q : 'z;
    assign oe0  = oe0_q;
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oe0_d   = oe0_q;
        last_d  = last_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (req_a2b || req_b2a) begin
                oe0_d   = grant_dir;
                last_d  = grant_dir;
                cnt_d   = TA_M1;
                state_d = TURN;
            end
            TURN: if (cnt_q == '0) state_d = CAP;
                  else cnt_d = cnt_q - CW'(1);
            CAP: begin
                data_d  = oe0_q ? busb : busa;
                cnt_d   = HOLD_M1;
                state_d = DRV;
            end
            default: if (cnt_q == '0) state_d = IDLE;
                     else cnt_d = cnt_q - CW'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oe0_q   <= 1'b0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oe0_q   <= oe0_d;
            last_q  <= last_d;
            data_q  <= data_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DRV && cnt_d == '0;
        end
    end
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: directed bench for bus_xfer_ctrl (default TA/HOLD plus a TA=3, HOLD=1 instance).
module tb_bus_xfer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] busa, busb, busa2, busb2;
    logic [15:0] a_val = '0, b_val = '0;
    logic a_en = 1'b0, b_en = 1'b0;
    assign busa = a_en ? a_val : 'z;
    assign busb = b_en ? b_val : 'z;
    pullup (busa);
    pullup (busb);
    pullup (busa2);
    pullup (busb2);

    logic req_a2b = 1'b0, req_b2a = 1'b0, req2_a2b = 1'b0, req2_b2a = 1'b0;
    logic oe0, busy, done, oe0_2, busy2, done2;
    logic [15:0] data_q, data_q2;
    int checks = 0, errors = 0;

    bus_xfer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .busa(busa), .busb(busb),
        .req_a2b(req_a2b), .req_b2a(req_b2a),
        .oe0(oe0), .busy(busy), .done(done), .data_q(data_q)
    );

    bus_xfer_ctrl #(.WIDTH(16), .TA(3), .HOLD(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .busa(busa2), .busb(busb2),
        .req_a2b(req2_a2b), .req_b2a(req2_b2a),
        .oe0(oe0_2), .busy(busy2), .done(done2), .data_q(data_q2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (!(busa === 'z || busa === 16'hFFFF)) begin errors++; $display("FAIL reset_busa got %h want released", busa); end
        checks++; if (!(busb === 'z || busb === 16'hFFFF)) begin errors++; $display("FAIL reset_busb got %h want released", busb); end
        checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL reset_oe0 got %b want 0", oe0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (data_q !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", data_q); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({busy, done, oe0, data_q} !== 19'd0) begin errors++; $display("FAIL idle_outputs cyc %0d got %b%b%b %h want 000 0000", i, busy, done, oe0, data_q); end
            checks++; if (!(busb === 'z || busb === 16'hFFFF)) begin errors++; $display("FAIL idle_busb cyc %0d got %h want released", i, busb); end
        end
    endtask

    task automatic test_a2b;
        logic exp_busy [5] = '{1, 1, 1, 1, 0};
        logic exp_done [5] = '{0, 0, 0, 1, 0};
        logic exp_drv  [5] = '{0, 0, 1, 1, 0};
        a_val = 16'hA5C3; a_en = 1'b1;
        req_a2b = 1'b1;
        tick();
        req_a2b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL a2b_busy k+%0d got %b want %b", i + 1, busy, exp_busy[i]); end
            checks++; if (done !== exp_done[i]) begin errors++; $display("FAIL a2b_done k+%0d got %b want %b", i + 1, done, exp_done[i]); end
            checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL a2b_oe0 k+%0d got %b want 0", i + 1, oe0); end
            checks++;
            if (exp_drv[i] ? (busb !== 16'hA5C3) : !(busb === 'z || busb === 16'hFFFF)) begin
                errors++; $display("FAIL a2b_busb k+%0d got %h want %s", i + 1, busb, exp_drv[i] ? "a5c3" : "released");
            end
            if (i >= 2) begin
                checks++; if (data_q !== 16'hA5C3) begin errors++; $display("FAIL a2b_data k+%0d got %h want a5c3", i + 1, data_q); end
            end
            tick();
        end
        a_en = 1'b0;
    endtask

    task automatic test_b2a_repeat;
        logic exp_busy [6] = '{1, 1, 1, 1, 0, 1};
        logic exp_done [6] = '{0, 0, 0, 1, 0, 0};
        logic exp_drv  [6] = '{0, 0, 1, 1, 0, 0};
        b_val = 16'h1234; b_en = 1'b1;
        req_b2a = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL b2a_busy k+%0d got %b want %b", i + 1, busy, exp_busy[i]); end
            checks++; if (done !== exp_done[i]) begin errors++; $display("FAIL b2a_done k+%0d got %b want %b", i + 1, done, exp_done[i]); end
            checks++; if (oe0 !== 1'b1) begin errors++; $display("FAIL b2a_oe0 k+%0d got %b want 1", i + 1, oe0); end
            checks++;
            if (exp_drv[i] ? (busa !== 16'h1234) : !(busa === 'z || busa === 16'hFFFF)) begin
                errors++; $display("FAIL b2a_busa k+%0d got %h want %s", i + 1, busa, exp_drv[i] ? "1234" : "released");
            end
            tick();
        end
        req_b2a = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2a_second_end busy got %b want 0", busy); end
        checks++; if (data_q !== 16'h1234) begin errors++; $display("FAIL b2a_data got %h want 1234", data_q); end
        b_en = 1'b0;
    endtask

    task automatic test_round_robin;
        logic exp_oe0 [3] = '{0, 1, 0};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req_a2b = 1'b1; req_b2a = 1'b1;
        tick();
        for (int t = 0; t < 3; t++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy grant %0d got %b want 1", t, busy); end
            checks++; if (oe0 !== exp_oe0[t]) begin errors++; $display("FAIL rr_oe0 grant %0d got %b want %b", t, oe0, exp_oe0[t]); end
            if (t < 2) repeat (5) tick();
        end
        req_a2b = 1'b0; req_b2a = 1'b0;
        repeat (4) tick();
        checks++; if ({busy, oe0} !== 2'b00) begin errors++; $display("FAIL rr_end busy/oe0 got %b%b want 00", busy, oe0); end
    endtask

    task automatic test_reset_mid_drv;
        a_val = 16'h0F0F; a_en = 1'b1;
        req_a2b = 1'b1;
        tick();
        req_a2b = 1'b0;
        tick();
        tick();
        checks++; if (busb !== 16'h0F0F) begin errors++; $display("FAIL mid_pre_busb got %h want 0f0f", busb); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (!(busb === 'z || busb === 16'hFFFF)) begin errors++; $display("FAIL mid_async_busb got %h want released", busb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (data_q !== 16'h0000) begin errors++; $display("FAIL mid_data got %h want 0000", data_q); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mid_after busy/done got %b%b want 00", busy, done); end
        checks++; if (!(busb === 'z || busb === 16'hFFFF)) begin errors++; $display("FAIL mid_after_busb got %h want released", busb); end
        a_en = 1'b0;
    endtask

    task automatic test_float_source;
        logic exp_busy [6] = '{1, 1, 1, 1, 1, 0};
        logic exp_done [6] = '{0, 0, 0, 0, 1, 0};
        req2_a2b = 1'b1;
        tick();
        req2_a2b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (busy2 !== exp_busy[i]) begin errors++; $display("FAIL float_busy k+%0d got %b want %b", i + 1, busy2, exp_busy[i]); end
            checks++; if (done2 !== exp_done[i]) begin errors++; $display("FAIL float_done k+%0d got %b want %b", i + 1, done2, exp_done[i]); end
            checks++; if (oe0_2 !== 1'b0) begin errors++; $display("FAIL float_oe0 k+%0d got %b want 0", i + 1, oe0_2); end
            checks++; if (!(busa2 === 'z || busa2 === 16'hFFFF)) begin errors++; $display("FAIL float_busa k+%0d got %h want released", i + 1, busa2); end
            checks++; if (!(busb2 === 'z || busb2 === 16'hFFFF)) begin errors++; $display("FAIL float_busb k+%0d got %h want ffff/released", i + 1, busb2); end
            checks++;
            if (data_q2 !== (i >= 4 ? 16'hFFFF : 16'h0000)) begin
                errors++; $display("FAIL float_data k+%0d got %h want %h", i + 1, data_q2, i >= 4 ? 16'hFFFF : 16'h0000);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_a2b();
        test_b2a_repeat();
        test_round_robin();
        test_reset_mid_drv();
        test_float_source();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
